extclk_counter: RTL and testbench
=================================

Name: extclk_counter

Overview:
- Parametrised successor to the 125 MHz timestamp counter block.
- Runs entirely in the local clk domain; synchronises an external reference frequency and measures its period in clk cycles.
- Maintains a lock state machine and drives a gated, prescaled timestamp counter that runs only when the reference is locked and not inhibited.
- Sits between the external clock input pad and the trigger/timestamp logic.

Parameters:
- CNT_WIDTH, 22: width of the timestamp counter output.
- PRESCALE, 2: clk cycles per timestamp increment; legal range 1..16.
- REF_RATIO, 8: expected clk cycles per freqin period; legal range 4..100.
- TOL, 1: allowed |period − REF_RATIO| deviation.
- LOCK_COUNT, 4: consecutive good periods required to declare lock; legal range 1..15.
- PW, 8: width of the period measurement; must satisfy 2^PW > 2*REF_RATIO.

Ports:
- clk  in  1  local system clock (125 MHz)
- reset  in  1  asynchronous, active-high reset
- freqin  in  1  external reference, asynchronous to clk
- inhibit  in  1  counter inhibit, clk domain
- lost_clr  in  1  single-cycle clear of the sticky lost flag
- counter  out  CNT_WIDTH  timestamp counter
- period  out  PW  last measured freqin period, in clk cycles
- locked  out  1  reference locked
- lost  out  1  sticky: lock was lost since the last lost_clr

Behaviour:
- Reset values:
  - counter=0, period=0, locked=0, lost=0.
  - Internal inhibit latch inh=1; FSM state=UNLOCKED; good-count=0; prescaler=0; pcnt=0; first=1.
- freqin synchronisation:
  - 2-FF synchroniser, then a third FF for rising-edge detect.
  - edge asserts 3 clk after a freqin rise, ±1 clk of sampling uncertainty.
- Period counter pcnt:
  - Increments each clk; saturates at 2^PW−1.
  - On edge: pcnt <= 0. If first=0, period <= pcnt+1, saturated at 2^PW−1; a saturated measurement is never good.
  - first is cleared on the first edge after reset or after a timeout. That first edge updates neither period nor the FSM.
- good = edge & ~first & (|measured − REF_RATIO| <= TOL), evaluated on the measured value of the same cycle.
- bad = edge & ~first & ~good.
- timeout = pcnt reaches 2*REF_RATIO with no edge in that cycle.
- FSM:
  - UNLOCKED: good → good-count=1, go to ACQUIRE (go straight to LOCKED if LOCK_COUNT=1).
  - ACQUIRE: good → good-count+1; when it reaches LOCK_COUNT → LOCKED. bad → good-count=0, go to UNLOCKED. timeout → UNLOCKED, first=1.
  - LOCKED: bad or timeout → UNLOCKED, good-count=0, lost <= 1. timeout additionally sets first=1.
  - locked = (state==LOCKED), registered; it rises the cycle after the LOCK_COUNT-th good edge.
- lost:
  - Sticky; cleared by lost_clr.
  - If the set condition and lost_clr coincide, set wins.
- Counter:
  - inh <= inhibit each clk (one-cycle latch).
  - If inh=1 or locked=0: counter=0 and prescaler=0.
  - Otherwise the prescaler counts 0..PRESCALE−1, and counter increments on prescaler wrap.
  - counter wraps modulo 2^CNT_WIDTH with no flag.
  - First increment occurs PRESCALE clk after the gate opens.
- Loss of lock clears counter on the cycle after locked falls.
- Async reset mid-operation returns every register to its reset value immediately; no partial state survives.

Test Plan:
1. Reset, then freqin period 8 clk, defaults → period=8 after the 2nd edge; locked=1 one clk after the 5th edge (4 good periods); counter then increments every 2 clk.
2. Locked, inhibit=0; one freqin period of 11 clk → bad edge; locked=0, lost=1, counter=0 next clk; relock after 4 further good periods; lost stays 1 until a lost_clr pulse.
3. Locked; freqin stops → timeout at pcnt=16; locked=0, lost=1. freqin resumes → first edge ignored, relock after 4 good periods.
4. Periods 7 and 9 (within TOL=1) → lock maintained. Period 10 or 6 → lock dropped.
5. CNT_WIDTH=4, PRESCALE=1, locked and uninhibited → counter 0..15 then 0, no stall.
6. inhibit=1 while locked → counter=0 two clk later, period/locked unaffected. inhibit released → first increment PRESCALE clk after inh falls. Assert reset mid-count → all outputs 0 immediately.

Source files
------------

// File: rtl/extclk_counter.sv
// extclk_counter: measures an external reference period in clk cycles, tracks lock,
// and runs a gated, prescaled timestamp counter while locked and not inhibited.
module extclk_counter #(
  parameter int CNT_WIDTH  = 22,
  parameter int PRESCALE   = 2,
  parameter int REF_RATIO  = 8,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 4,
  parameter int PW         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 freqin,
  input  logic                 inhibit,
  input  logic                 lost_clr,
  output logic [CNT_WIDTH-1:0] counter,
  output logic [PW-1:0]        period,
  output logic                 locked,
  output logic                 lost
);
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
  localparam logic [PW-1:0] PMAX = '1;
  localparam logic [PW-1:0] TMO  = PW'(2 * REF_RATIO);
  localparam logic [PW-1:0] LO   = PW'(REF_RATIO - TOL);
  localparam logic [PW-1:0] HI   = PW'(REF_RATIO + TOL);
  localparam logic [3:0]    LC   = 4'(LOCK_COUNT);
  localparam logic [4:0]    PS   = 5'(PRESCALE - 1);
  state_t state;
  logic [2:0] sync;
  logic [PW-1:0] pcnt, meas;
  logic [3:0] gc;
  logic [4:0] presc;
  logic first, inh, fedge, good, bad, tmo;
  assign fedge = sync[1] & ~sync[2];
  assign meas  = (pcnt == PMAX) ? PMAX : pcnt + 1'b1;
  // A saturated measurement can never be a good period, whatever TOL is.
  assign good  = fedge & ~first & (meas != PMAX) & (meas >= LO) & (meas <= HI);
  assign bad   = fedge & ~first & ~good;
  assign tmo   = ~fedge & (pcnt == TMO);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync   <= '0;
      pcnt   <= '0;
      period <= '0;
      first  <= 1'b1;
      state  <= UNLOCKED;
      gc     <= '0;
      locked <= 1'b0;
      lost   <= 1'b0;
    end else begin
      sync <= {sync[1:0], freqin};
      pcnt <= fedge ? '0 : (pcnt == PMAX) ? pcnt : pcnt + 1'b1;
      if (fedge & ~first) period <= meas;
      if (fedge) first <= 1'b0;
      else if (tmo & (state != UNLOCKED)) first <= 1'b1;
      lost <= ((state == LOCKED) & (bad | tmo)) | (lost & ~lost_clr);
      case (state)
        UNLOCKED:
          if (good) begin
            gc     <= 4'd1;
            state  <= (LC == 4'd1) ? LOCKED : ACQUIRE;
            locked <= (LC == 4'd1);
          end
        ACQUIRE:
          if (good) begin
            gc <= gc + 1'b1;
            if (gc + 1'b1 == LC) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end else if (bad | tmo) begin
            gc    <= '0;
            state <= UNLOCKED;
          end
        LOCKED:
          if (bad | tmo) begin
            gc     <= '0;
            state  <= UNLOCKED;
            locked <= 1'b0;
          end
        default: state <= UNLOCKED;
      endcase
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      inh     <= 1'b1;
      presc   <= '0;
      counter <= '0;
    end else begin
      inh <= inhibit;
      if (inh | ~locked) begin
        presc   <= '0;
        counter <= '0;
      end else if (presc == PS) begin
        presc   <= '0;
        counter <= counter + 1'b1;
      end else presc <= presc + 1'b1;
    end
endmodule

// File: tb/tb_extclk_counter.sv
// tb_extclk_counter: randomized reference-clock stimulus checked against a behavioural
// model of period measurement, lock tracking and gated timestamp counting.
module tb_extclk_counter;
  localparam int REF = 8, TOL = 1, LC = 4, PS = 2;
  logic clk = 0, reset = 1, freqin = 0, inhibit = 0, lost_clr = 0;
  logic [21:0] counter;
  logic [7:0] period, period2;
  logic [3:0] counter2;
  logic locked, lost, locked2, lost2;
  int vecs = 0, errs = 0;
  int m_since, m_gc, m_period, m_run, meas;
  bit m_first, m_locked, m_lost, m_inh, e, good, bad, tmo;
  bit hist[$];

  extclk_counter dut (
    .clk(clk), .reset(reset), .freqin(freqin), .inhibit(inhibit), .lost_clr(lost_clr),
    .counter(counter), .period(period), .locked(locked), .lost(lost)
  );
  extclk_counter #(.CNT_WIDTH(4), .PRESCALE(1)) dut2 (
    .clk(clk), .reset(reset), .freqin(freqin), .inhibit(inhibit), .lost_clr(lost_clr),
    .counter(counter2), .period(period2), .locked(locked2), .lost(lost2)
  );

  always #5 clk = ~clk;

  // A freqin rise is acted on two samples after it is first seen; lock means
  // LOCK_COUNT good periods in a row with no bad period or timeout since.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_since = 0; m_gc = 0; m_period = 0; m_run = 0;
      m_first = 1; m_locked = 0; m_lost = 0; m_inh = 1;
      hist = '{0, 0, 0};
    end else begin
      e = hist[1] && !hist[0];
      hist.push_back(freqin);
      void'(hist.pop_front());
      meas = (m_since + 1 > 255) ? 255 : m_since + 1;
      tmo = !e && m_since == 2 * REF;
      good = e && !m_first && meas < 255 && meas >= REF - TOL && meas <= REF + TOL;
      bad = e && !m_first && !good;
      m_run = (!m_inh && m_locked) ? m_run + 1 : 0;
      m_inh = inhibit;
      m_lost = (m_locked && (bad || tmo)) || (m_lost && !lost_clr);
      if (e && !m_first) m_period = meas;
      m_first = e ? 1'b0 : (tmo && m_gc > 0) ? 1'b1 : m_first;
      m_gc = good ? m_gc + 1 : (bad || tmo) ? 0 : m_gc;
      m_locked = m_gc >= LC;
      m_since = e ? 0 : (m_since < 255 ? m_since + 1 : 255);
    end
  end

  function automatic logic [45:0] mdl_vec();
    return {22'((m_run / PS) % (1 << 22)), 8'(m_period), m_locked, m_lost,
            4'(m_run % 16), 8'(m_period), m_locked, m_lost};
  endfunction

  function automatic logic [45:0] dut_vec();
    return {counter, period, locked, lost, counter2, period2, locked2, lost2};
  endfunction

  task automatic step(input bit f, input bit clr, input bit ih);
    @(negedge clk);
    freqin = f; lost_clr = clr; inhibit = ih;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    step(0, 0, 0);
    step(1, 0, 0);
    vecs++;
    if (dut_vec() !== 46'd0) begin errs++; $display("FAIL reset_hold: got %h exp 0", dut_vec()); end
    @(negedge clk) reset = 0;
    for (int c = 0; c < 6; c++) step(0, 0, 0);
    vecs++;
    if (dut_vec() !== 46'd0) begin errs++; $display("FAIL reset_idle: got %h exp 0", dut_vec()); end
  endtask

  task automatic test_lock();
    int n = 0;
    bit pl = 0;
    for (int c = 0; c < 64; c++) begin
      step(c % 8 < 4, 0, 0);
      vecs++;
      if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL lock c%0d: got %h exp %h", c, dut_vec(), mdl_vec()); end
      if (pl) begin
        n++;
        vecs++;
        if (counter !== 22'(n / PS)) begin errs++; $display("FAIL lock_count c%0d: got %0d exp %0d", c, counter, n / PS); end
      end
      pl = m_locked;
    end
    vecs++;
    if ({locked, period} !== {1'b1, 8'd8}) begin errs++; $display("FAIL lock_final: got %b/%0d exp 1/8", locked, period); end
  endtask

  task automatic test_bad_period();
    int pers[7] = '{0, 8, 8, 8, 8, 8, 8};
    pers[0] = $urandom_range(0, 1) ? $urandom_range(10, 14) : $urandom_range(5, 6);
    for (int p = 0; p < 7; p++)
      for (int i = 0; i < pers[p]; i++) begin
        step(i < pers[p] / 2, (p == 1 && i <= 2) || (p == 6 && i == 5), 0);
        vecs++;
        if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL bad p%0d i%0d: got %h exp %h", p, i, dut_vec(), mdl_vec()); end
        if (p == 6 && i == 4) begin
          vecs++;
          if (lost !== 1'b1) begin errs++; $display("FAIL bad_sticky: got %b exp 1", lost); end
        end
      end
    vecs++;
    if ({locked, lost} !== 2'b10) begin errs++; $display("FAIL bad_relock: got %b%b exp 10", locked, lost); end
  endtask

  task automatic test_timeout();
    for (int c = 0; c < 25; c++) begin
      step(0, 0, 0);
      vecs++;
      if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL tmo c%0d: got %h exp %h", c, dut_vec(), mdl_vec()); end
    end
    vecs++;
    if ({locked, lost, counter} !== {1'b0, 1'b1, 22'd0}) begin errs++; $display("FAIL tmo_drop: got %b%b/%0d exp 01/0", locked, lost, counter); end
    for (int c = 0; c < 64; c++) begin
      step(c % 8 < 4, 0, 0);
      vecs++;
      if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL tmo_relock c%0d: got %h exp %h", c, dut_vec(), mdl_vec()); end
    end
    vecs++;
    if (locked !== 1'b1) begin errs++; $display("FAIL tmo_relock_final: got %b exp 1", locked); end
  endtask

  task automatic test_tolerance();
    int per;
    for (int p = 0; p < 10; p++) begin
      per = $urandom_range(7, 9);
      for (int i = 0; i < per; i++) begin
        step(i < per / 2, 0, 0);
        vecs++;
        if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL tol p%0d i%0d: got %h exp %h", p, i, dut_vec(), mdl_vec()); end
      end
    end
    vecs++;
    if (locked !== 1'b1) begin errs++; $display("FAIL tol_hold: got %b exp 1", locked); end
    for (int q = 0; q < 2; q++) begin
      per = (q == 0) ? ($urandom_range(0, 1) ? 10 : 6) : 8;
      for (int i = 0; i < per; i++) begin
        step(i < per / 2, 0, 0);
        vecs++;
        if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL tol_out q%0d i%0d: got %h exp %h", q, i, dut_vec(), mdl_vec()); end
      end
    end
    vecs++;
    if (locked !== 1'b0) begin errs++; $display("FAIL tol_drop: got %b exp 0", locked); end
  endtask

  task automatic test_wrap();
    int n = 0;
    bit pl = 0;
    for (int c = 0; c < 80; c++) begin
      step(c % 8 < 4, 0, 0);
      vecs++;
      if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL wrap c%0d: got %h exp %h", c, dut_vec(), mdl_vec()); end
      if (pl) begin
        n++;
        vecs++;
        if (counter2 !== 4'(n % 16)) begin errs++; $display("FAIL wrap_count c%0d: got %0d exp %0d", c, counter2, n % 16); end
      end
      pl = m_locked;
    end
  endtask

  task automatic test_inhibit();
    for (int c = 0; c < 24; c++) begin
      step(c % 8 < 4, 0, c < 6);
      vecs++;
      if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL inh c%0d: got %h exp %h", c, dut_vec(), mdl_vec()); end
      if (c == 1) begin
        vecs++;
        if ({counter, locked, period} !== {22'd0, 1'b1, 8'd8}) begin errs++; $display("FAIL inh_gate: got %0d/%b/%0d exp 0/1/8", counter, locked, period); end
      end
      if (c == 7 || c == 8) begin
        vecs++;
        if (counter !== 22'(c - 7)) begin errs++; $display("FAIL inh_release c%0d: got %0d exp %0d", c, counter, c - 7); end
      end
    end
    #2 reset = 1;
    #1;
    vecs++;
    if (dut_vec() !== 46'd0) begin errs++; $display("FAIL async_reset: got %h exp 0", dut_vec()); end
    @(negedge clk) reset = 0;
  endtask

  task automatic test_random();
    int per, r;
    bit ih;
    for (int p = 0; p < 40; p++) begin
      r = $urandom_range(0, 9);
      per = (r == 0) ? 24 : (r < 3) ? $urandom_range(4, 14) : $urandom_range(7, 9);
      ih = $urandom_range(0, 5) == 0;
      for (int i = 0; i < per; i++) begin
        step(i < per / 2, $urandom_range(0, 15) == 0, ih);
        vecs++;
        if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL rand p%0d i%0d: got %h exp %h", p, i, dut_vec(), mdl_vec()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_bad_period();
    test_timeout();
    test_tolerance();
    test_wrap();
    test_inhibit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
